// File: rtl/instr_encoder.sv
// Instruction encoder: turns mnemonic-level instructions into 32-bit MIPS words and writes them to instruction memory.
// Latency: a word accepted in cycle k sits in the encode stage in k+1, and mem_we can first be high in cycle k+2.
// Backpressure: in_ready drops once FIFO + stage hold DEPTH words; a low mem_ready holds mem_addr/mem_wdata steady.
// Optional feature: define INSTR_ENC_CHKSUM_EN to add the chksum output (XOR of every word written this session).

module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  logic [W-1:0]               mem [DEPTH];
  logic [$clog2(DEPTH)-1:0]   wp;
  logic [$clog2(DEPTH)-1:0]   rp;

  // Storage, read/write pointers and occupancy; push and pop on the same edge leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rp];
endmodule

module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] word_count
`ifdef INSTR_ENC_CHKSUM_EN
  ,
  output logic [31:0]       chksum
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   stg_vld;
  logic [31:0]            stg_word;
  logic [31:0]            enc_word;
  logic [31:0]            fifo_head;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                   accept, legal, pop, start_ok;

  assign accept   = in_valid && in_ready;
  assign legal    = (in_mnem <= 4'd12);
  assign pop      = mem_we && mem_ready;
  assign start_ok = (state == IDLE) && start;
  assign in_ready = (state == RUN) && ((32'(fifo_cnt) + 32'(stg_vld)) < DEPTH);
  assign mem_we   = (fifo_cnt != '0);
  assign mem_wdata = mem_we ? fifo_head : 32'd0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Field packing per mnemonic; rs is zeroed for SLL/SRL, shamt kept only for SLL/SRL/ROT.
  always_comb begin
    enc_word = 32'd0;
    case (in_mnem)
      4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0,     6'h20};
      4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0,     6'h22};
      4'd2:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0,     6'h24};
      4'd3:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0,     6'h25};
      4'd4:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0,     6'h2A};
      4'd5:    enc_word = {6'h00, 5'd0,  in_rt, in_rd, in_shamt, 6'h00};
      4'd6:    enc_word = {6'h00, 5'd0,  in_rt, in_rd, in_shamt, 6'h02};
      4'd7:    enc_word = {6'h1C, in_rs, in_rt, in_rd, 5'd0,     6'h11};
      4'd8:    enc_word = {6'h1C, in_rs, in_rt, in_rd, 5'd0,     6'h20};
      4'd9:    enc_word = {6'h1C, in_rs, in_rt, in_rd, 5'd0,     6'h02};
      4'd10:   enc_word = {6'h1C, in_rs, in_rt, in_rd, in_shamt, 6'h06};
      4'd11:   enc_word = {6'h08, in_rs, in_rt, in_imm};
      4'd12:   enc_word = {6'h0D, in_rs, in_rt, in_imm};
      default: enc_word = 32'd0;
    endcase
  end

  // Encode stage: illegal mnemonics complete the handshake but never occupy the stage.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stg_vld  <= 1'b0;
      stg_word <= '0;
    end else begin
      stg_vld <= accept && legal;
      if (accept && legal) stg_word <= enc_word;
    end
  end

  // The stage always has room in the FIFO because in_ready counts the stage against DEPTH.
  instr_enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (stg_vld),
    .wdata (stg_word),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_cnt)
  );

  // Session bookkeeping: address, word count and illegal flag restart on an accepted start.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_addr    <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else if (start_ok) begin
      mem_addr    <= BASE_ADDR;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (pop) begin
        mem_addr   <= mem_addr + ADDR_W'(4);
        word_count <= word_count + 1'b1;
      end
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end

`ifdef INSTR_ENC_CHKSUM_EN
  // Running XOR of completed writes, restarted with each session.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)           chksum <= '0;
    else if (start_ok) chksum <= '0;
    else if (pop)      chksum <= chksum ^ mem_wdata;
  end
`endif

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; DRAIN ends on the edge that empties the pipeline so done follows the last write by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (!stg_vld && ((fifo_cnt == '0) || ((32'(fifo_cnt) == 1) && pop))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table of hand-encoded words plus stall, flush and reset sequences.
// Expected writes are queued when a transfer is seen and compared when the memory port completes a write.
// All DUT outputs are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              start = 1'b0, flush = 1'b0, in_valid = 1'b0, mem_ready = 1'b1;
  logic [3:0]        in_mnem = '0;
  logic [4:0]        in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0;
  logic [15:0]       in_imm = '0;
  logic              in_ready, mem_we, busy, done, err_illegal;
  logic [ADDR_W-1:0] mem_addr, word_count;
  logic [31:0]       mem_wdata;
`ifdef INSTR_ENC_CHKSUM_EN
  logic [31:0]       chksum;
`endif

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_illegal(err_illegal), .word_count(word_count)
`ifdef INSTR_ENC_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rd, rs, rt, sh;
    logic [15:0] imm;
    logic [31:0] exp;
    bit          legal;
  } vec_t;

  vec_t              tv [14];
  logic [31:0]       exp_w [$];
  logic [ADDR_W-1:0] exp_a [$];
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       exp_cs;
  int                vecs = 0;
  int                errs = 0;
  int                writes_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] m, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [31:0] exp, input bit legal);
    tv[i].mnem = m; tv[i].rd = rd; tv[i].rs = rs; tv[i].rt = rt; tv[i].sh = sh;
    tv[i].imm = imm; tv[i].exp = exp; tv[i].legal = legal;
  endtask

  // Scoreboard: every completed write must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (!Rst && mem_we && mem_ready) begin
      writes_seen++;
      if (exp_w.size() == 0) begin
        chk("unexpected_write", mem_wdata, 32'hXXXXXXXX);
      end else begin
        chk("wr_addr", 32'(mem_addr), 32'(exp_a[0]));
        chk("wr_data", mem_wdata, exp_w[0]);
        exp_cs = exp_cs ^ exp_w[0];
        void'(exp_w.pop_front());
        void'(exp_a.pop_front());
      end
    end
  end

  task automatic drive(input int i);
    in_mnem = tv[i].mnem; in_rd = tv[i].rd; in_rs = tv[i].rs; in_rt = tv[i].rt;
    in_shamt = tv[i].sh; in_imm = tv[i].imm; in_valid = 1'b1;
  endtask

  task automatic push_exp(input int i);
    if (tv[i].legal) begin
      exp_w.push_back(tv[i].exp);
      exp_a.push_back(exp_addr);
      exp_addr = exp_addr + ADDR_W'(4);
    end
  endtask

  // Presents vector i at a falling edge and returns once in_ready is seen (transfer on the next rising edge).
  task automatic send(input int i);
    int t;
    @(negedge Clk);
    drive(i);
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else push_exp(i);
  endtask

  task automatic do_start();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    exp_addr = '0;
    exp_cs = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_w.size() != 0 || mem_we) && t < 300) begin
      @(negedge Clk);
      t++;
    end
    chk("drained", 32'(exp_w.size()), 32'd0);
  endtask

  task automatic flush_wait();
    int t = 0;
    @(negedge Clk); flush = 1'b1;
    @(negedge Clk); flush = 1'b0;
    while (!done && t < 300) begin
      @(negedge Clk);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge Clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int k, t, last_wr, done_at, done_n;
    logic [31:0] held;
    //        idx mnem  rd  rs  rt  sh  imm       expected      legal
    setv(0,  4'd0,  3,  1,  2,  0, 16'h0000, 32'h00221820, 1); // ADD
    setv(1,  4'd11, 9,  0,  5,  7, 16'hFFFF, 32'h2005FFFF, 1); // ADDI, rd/shamt ignored
    setv(2,  4'd5,  4,  7,  2,  3, 16'h0000, 32'h000220C0, 1); // SLL, rs forced 0
    setv(3,  4'd7,  1,  2,  0,  5, 16'h0000, 32'h70400811, 1); // CL1, shamt forced 0
    setv(4,  4'd1,  7,  8,  9,  5, 16'h0000, 32'h01093822, 1); // SUB
    setv(5,  4'd6, 10, 31, 11, 31, 16'h0000, 32'h000B57C2, 1); // SRL
    setv(6,  4'd10, 1,  2,  3,  4, 16'h0000, 32'h70430906, 1); // ROT keeps shamt
    setv(7,  4'd9,  5,  6,  7,  9, 16'h0000, 32'h70C72802, 1); // MUL
    setv(8,  4'd12,31,  1,  2, 31, 16'h1234, 32'h34221234, 1); // ORI
    setv(9,  4'd2,  3,  4,  5,  0, 16'h0000, 32'h00851824, 1); // AND
    setv(10, 4'd3,  1,  1,  1,  0, 16'h0000, 32'h00210825, 1); // OR
    setv(11, 4'd4,  2,  3,  4,  0, 16'h0000, 32'h0064102A, 1); // SLT
    setv(12, 4'd8,  8,  9,  0,  0, 16'h0000, 32'h71204020, 1); // CLZ
    setv(13, 4'd13, 1,  1,  1,  0, 16'h0000, 32'h00000000, 0); // illegal
    exp_addr = '0;
    exp_cs = '0;

    // Reset values.
    repeat (3) @(negedge Clk);
    chk("rst_flags", {27'd0, in_ready, mem_we, busy, done, err_illegal}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;

    // Session A: single ADD with latency check, then the table.
    do_start();
    chk("busy_run", 32'(busy), 32'd1);
    send(0);
    @(negedge Clk); in_valid = 1'b0;
    chk("lat_stage_no_we", 32'(mem_we), 32'd0);
    @(negedge Clk);
    chk("lat_we_2cyc", 32'(mem_we), 32'd1);
    wait_drain();
    chk("t1_count", 32'(word_count), 32'd1);
    chk("t1_addr_next", 32'(mem_addr), 32'd4);
    do_start();
    chk("start_in_run_ignored", 32'(word_count), 32'd1);
    exp_addr = ADDR_W'(4);
    exp_cs = 32'h00221820;
    for (int i = 1; i <= 12; i++) send(i);
    @(negedge Clk); in_valid = 1'b0;
    wait_drain();
    chk("tA_count", 32'(word_count), 32'd13);
    chk("tA_err", 32'(err_illegal), 32'd0);
`ifdef INSTR_ENC_CHKSUM_EN
    chk("chksum", chksum, exp_cs);
`endif
    flush_wait();

    // Session B: stall with 6 words offered against a 4-deep pipeline.
    do_start();
    mem_ready = 1'b0;
    k = 0;
    held = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (k < 6) drive(k);
      if (mem_we) begin
        if (held == 32'd0) held = mem_wdata;
        else chk("stall_stable", mem_wdata, tv[0].exp);
      end
      if (in_ready && k < 6) begin
        push_exp(k);
        k++;
      end
    end
    chk("stall_accepted", 32'(k), 32'(DEPTH));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head", held, tv[0].exp);
    @(posedge Clk); #1 mem_ready = 1'b1;
    t = 0;
    while (k < 6 && t < 100) begin
      @(negedge Clk);
      drive(k);
      if (in_ready) begin
        push_exp(k);
        k++;
      end
      t++;
    end
    chk("stall_all_sent", 32'(k), 32'd6);
    @(negedge Clk); in_valid = 1'b0;
    wait_drain();
    chk("tB_count", 32'(word_count), 32'd6);
    flush_wait();

    // Session C: illegal mnemonic between two legal ones.
    do_start();
    send(0);
    send(13);
    send(4);
    @(negedge Clk); in_valid = 1'b0;
    wait_drain();
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(word_count), 32'd2);
    chk("ill_addr", 32'(mem_addr), 32'd8);
    flush_wait();

    // Session D: flush with 3 words pending; done follows the last write by one cycle.
    do_start();
    chk("start_clears_err", 32'(err_illegal), 32'd0);
    mem_ready = 1'b0;
    send(1);
    send(2);
    send(3);
    @(negedge Clk); in_valid = 1'b0; flush = 1'b1;
    @(negedge Clk); flush = 1'b0;
    chk("drain_busy", 32'(busy), 32'd1);
    @(posedge Clk); #1 mem_ready = 1'b1;
    last_wr = -10; done_at = -1; done_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (mem_we && mem_ready) last_wr = c;
      if (done) begin
        done_at = c;
        done_n++;
      end
    end
    chk("done_after_last_wr", 32'(done_at), 32'(last_wr + 1));
    chk("done_width", 32'(done_n), 32'd1);
    chk("flush_busy_end", 32'(busy), 32'd0);
    chk("flush_count", 32'(word_count), 32'd3);

    // Session E: reset while draining drops everything.
    do_start();
    mem_ready = 1'b0;
    send(6);
    send(7);
    @(negedge Clk); in_valid = 1'b0; flush = 1'b1;
    @(negedge Clk); flush = 1'b0;
    @(posedge Clk); #1 Rst = 1'b1;
    @(negedge Clk);
    chk("rst_mid_flags", {27'd0, in_ready, mem_we, busy, done, err_illegal}, 32'd0);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    chk("rst_mid_wdata", mem_wdata, 32'd0);
    chk("rst_mid_count", 32'(word_count), 32'd0);
`ifdef INSTR_ENC_CHKSUM_EN
    chk("rst_mid_chksum", chksum, 32'd0);
`endif
    exp_w.delete();
    exp_a.delete();
    @(posedge Clk); #1 Rst = 1'b0; mem_ready = 1'b1;
    repeat (5) @(negedge Clk);
    chk("no_write_after_rst", 32'(mem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
